// File: rtl/vai_tx_auditor.sv
// Per-sub-AFU CCI-P Tx auditor: relocates c0/c1 request addresses by the VMID offset,
// blocks and drains traffic under soft reset, and reports when the sub-AFU is quiesced.
package vai_ccip_pkg;
  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_req_hdr;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic        sop;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_req_hdr;

  typedef struct packed {
    t_ccip_c0_req_hdr hdr;
    logic             valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_req_hdr hdr;
    logic [511:0]     data;
    logic             valid;
  } t_if_ccip_c1_Tx;
endpackage

module vai_tx_auditor
  import vai_ccip_pkg::*;
#(
  parameter int VMID   = 0,
  parameter int CNT_W  = 10,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              Resetb,
  input  logic [63:0]       offset,
  input  logic              afu_reset,
  input  t_if_ccip_c0_Tx    in_c0,
  input  t_if_ccip_c1_Tx    in_c1,
  input  logic              rsp_c0_line,
  input  logic              rsp_c1_line,
  output t_if_ccip_c0_Tx    out_c0,
  output t_if_ccip_c1_Tx    out_c1,
  output logic              quiesced,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              cnt_err
);
  typedef enum logic [1:0] {RUN, DRAIN, QUIET} state_t;

  state_t            state;
  t_if_ccip_c0_Tx    s1_c0;
  t_if_ccip_c1_Tx    s1_c1;
  logic [41:0]       s1_off;
  logic [CNT_W-1:0]  rd_out, wr_out, rd_nxt, wr_nxt;
  logic              rd_err, wr_err;
  logic              run_ok, adm0, adm1, drop0, drop1, idle;
  logic [2:0]        rd_add, wr_add;
  logic [1:0]        drop_inc;
  logic [DROP_W:0]   drop_sum;
  logic              unused_ok;

  // VMID only labels the instance; the upper offset bits are outside the 42-bit address space
  assign unused_ok = &{1'b0, offset[63:42], 1'(VMID)};

  assign run_ok   = (state == RUN) & ~afu_reset;
  assign adm0     = in_c0.valid & run_ok;
  assign adm1     = in_c1.valid & run_ok;
  assign drop0    = in_c0.valid & ~run_ok;
  assign drop1    = in_c1.valid & ~run_ok;
  assign rd_add   = adm0 ? {1'b0, in_c0.hdr.cl_len} + 3'd1 : 3'd0;
  assign wr_add   = adm1 ? {1'b0, in_c1.hdr.cl_len} + 3'd1 : 3'd0;
  assign drop_inc = {1'b0, drop0} + {1'b0, drop1};
  assign drop_sum = {1'b0, drop_cnt} + {{(DROP_W-1){1'b0}}, drop_inc};
  assign idle     = (rd_out == '0) & (wr_out == '0) & ~s1_c0.valid & ~s1_c1.valid
                  & ~out_c0.valid & ~out_c1.valid;

  // Net add/subtract in a widened sum; underflow holds at 0, overflow saturates, both flag.
  function automatic void cnt_upd(input logic [CNT_W-1:0] cur, input logic [2:0] add,
                                  input logic dec, output logic [CNT_W-1:0] nxt,
                                  output logic err);
    logic [CNT_W+1:0] t;
    t   = {2'b00, cur} + {{(CNT_W-1){1'b0}}, add};
    err = 1'b0;
    if (dec) begin
      if (t == '0) err = 1'b1;
      else         t = t - {{(CNT_W+1){1'b0}}, 1'b1};
    end
    if (t > {2'b00, {CNT_W{1'b1}}}) begin
      t   = {2'b00, {CNT_W{1'b1}}};
      err = 1'b1;
    end
    nxt = t[CNT_W-1:0];
  endfunction

  always_comb begin
    rd_nxt = '0;
    wr_nxt = '0;
    rd_err = 1'b0;
    wr_err = 1'b0;
    cnt_upd(rd_out, rd_add, rsp_c0_line, rd_nxt, rd_err);
    cnt_upd(wr_out, wr_add, rsp_c1_line, wr_nxt, wr_err);
  end

  always_ff @(posedge clk or negedge Resetb) begin
    if (!Resetb) begin
      s1_c0    <= '0;
      s1_c1    <= '0;
      s1_off   <= '0;
      out_c0   <= '0;
      out_c1   <= '0;
      rd_out   <= '0;
      wr_out   <= '0;
      drop_cnt <= '0;
      cnt_err  <= 1'b0;
      quiesced <= 1'b0;
      state    <= RUN;
    end else begin
      s1_c0       <= in_c0;
      s1_c0.valid <= adm0;
      s1_c1       <= in_c1;
      s1_c1.valid <= adm1;
      s1_off      <= offset[41:0];

      // Offset captured alongside the request so later offset updates cannot touch it
      out_c0             <= s1_c0;
      out_c0.hdr.address <= s1_c0.hdr.address + s1_off;
      out_c1             <= s1_c1;
      out_c1.hdr.address <= s1_c1.hdr.address + s1_off;

      rd_out   <= rd_nxt;
      wr_out   <= wr_nxt;
      drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
      if (rd_err | wr_err | ((state == QUIET) & (rsp_c0_line | rsp_c1_line)))
        cnt_err <= 1'b1;

      unique case (state)
        RUN: if (afu_reset) state <= DRAIN;
        DRAIN: begin
          if (!afu_reset) state <= RUN;
          else if (idle) begin
            state    <= QUIET;
            quiesced <= 1'b1;
          end
        end
        QUIET: if (!afu_reset) begin
          state    <= RUN;
          quiesced <= 1'b0;
        end
        default: begin
          state    <= RUN;
          quiesced <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vai_tx_auditor.sv
// Randomized and directed bench for vai_tx_auditor against a transaction-level reference model.
module tb_vai_tx_auditor;
  import vai_ccip_pkg::*;

  localparam int CNT_W  = 4;
  localparam int DROP_W = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int DMAX   = (1 << DROP_W) - 1;
  localparam int M_RUN = 0, M_DRAIN = 1, M_QUIET = 2;

  logic              clk = 1'b0;
  logic              Resetb;
  logic [63:0]       offset;
  logic              afu_reset;
  t_if_ccip_c0_Tx    in_c0, out_c0;
  t_if_ccip_c1_Tx    in_c1, out_c1;
  logic              rsp_c0_line, rsp_c1_line;
  logic              quiesced, cnt_err;
  logic [DROP_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: expected output pipeline, line counts, drop count, mode
  t_if_ccip_c0_Tx m_p1_c0, m_p2_c0;
  t_if_ccip_c1_Tx m_p1_c1, m_p2_c1;
  int m_rd, m_wr, m_drop, m_mode;
  bit m_err, m_q;

  vai_tx_auditor #(.VMID(3), .CNT_W(CNT_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .Resetb(Resetb), .offset(offset), .afu_reset(afu_reset),
    .in_c0(in_c0), .in_c1(in_c1), .rsp_c0_line(rsp_c0_line), .rsp_c1_line(rsp_c1_line),
    .out_c0(out_c0), .out_c1(out_c1), .quiesced(quiesced), .drop_cnt(drop_cnt),
    .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_p1_c0 = '0; m_p2_c0 = '0; m_p1_c1 = '0; m_p2_c1 = '0;
    m_rd = 0; m_wr = 0; m_drop = 0; m_mode = M_RUN; m_err = 0; m_q = 0;
  endtask

  task automatic model_step();
    bit ok, idle;
    int r, w, d;
    ok   = (m_mode == M_RUN) && !afu_reset;
    idle = (m_rd == 0) && (m_wr == 0) && !m_p1_c0.valid && !m_p1_c1.valid
        && !m_p2_c0.valid && !m_p2_c1.valid;
    if (m_mode == M_QUIET && (rsp_c0_line || rsp_c1_line)) m_err = 1;
    r = m_rd + ((ok && in_c0.valid) ? int'(in_c0.hdr.cl_len) + 1 : 0);
    if (rsp_c0_line) begin if (r == 0) m_err = 1; else r--; end
    if (r > CMAX) begin r = CMAX; m_err = 1; end
    w = m_wr + ((ok && in_c1.valid) ? int'(in_c1.hdr.cl_len) + 1 : 0);
    if (rsp_c1_line) begin if (w == 0) m_err = 1; else w--; end
    if (w > CMAX) begin w = CMAX; m_err = 1; end
    m_rd = r; m_wr = w;
    d = m_drop + ((in_c0.valid && !ok) ? 1 : 0) + ((in_c1.valid && !ok) ? 1 : 0);
    m_drop = (d > DMAX) ? DMAX : d;
    m_p2_c0 = m_p1_c0;
    m_p2_c1 = m_p1_c1;
    m_p1_c0 = in_c0;
    m_p1_c0.valid = in_c0.valid && ok;
    m_p1_c0.hdr.address = in_c0.hdr.address + offset[41:0];
    m_p1_c1 = in_c1;
    m_p1_c1.valid = in_c1.valid && ok;
    m_p1_c1.hdr.address = in_c1.hdr.address + offset[41:0];
    case (m_mode)
      M_RUN:   if (afu_reset) m_mode = M_DRAIN;
      M_DRAIN: if (!afu_reset) m_mode = M_RUN; else if (idle) m_mode = M_QUIET;
      default: if (!afu_reset) m_mode = M_RUN;
    endcase
    m_q = (m_mode == M_QUIET);
  endtask

  task automatic tick();
    @(posedge clk);
    if (Resetb) model_step(); else model_reset();
    #1;
  endtask

  task automatic idle_in();
    in_c0 = '0; in_c1 = '0; rsp_c0_line = 0; rsp_c1_line = 0;
  endtask

  task automatic do_reset();
    Resetb = 0; afu_reset = 0; offset = '0;
    idle_in();
    model_reset();
    tick(); tick();
    Resetb = 1;
  endtask

  function automatic t_if_ccip_c0_Tx rand_c0(input bit v);
    t_if_ccip_c0_Tx r;
    logic [63:0] a;
    a = {$urandom, $urandom};
    r.valid = v;
    r.hdr.vc_sel = 2'($urandom);
    r.hdr.cl_len = 2'($urandom);
    r.hdr.req_type = 4'($urandom);
    r.hdr.address = a[41:0];
    r.hdr.mdata = 16'($urandom);
    return r;
  endfunction

  function automatic t_if_ccip_c1_Tx rand_c1(input bit v);
    t_if_ccip_c1_Tx r;
    logic [63:0] a;
    a = {$urandom, $urandom};
    r.valid = v;
    r.hdr.vc_sel = 2'($urandom);
    r.hdr.sop = 1'($urandom);
    r.hdr.cl_len = 2'($urandom);
    r.hdr.req_type = 4'($urandom);
    r.hdr.address = a[41:0];
    r.hdr.mdata = 16'($urandom);
    for (int k = 0; k < 16; k++) r.data[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    Resetb = 0; afu_reset = 0; offset = 64'h1234;
    in_c0 = rand_c0(1); in_c1 = rand_c1(1); rsp_c0_line = 1; rsp_c1_line = 1;
    model_reset();
    tick(); tick();
    n_checks++;
    if (out_c0.valid !== 1'b0 || out_c1.valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b%b want 00", out_c0.valid, out_c1.valid);
    end
    n_checks++;
    if (quiesced !== 1'b0 || cnt_err !== 1'b0 || drop_cnt !== '0) begin
      n_fail++; $display("FAIL reset_status: got q=%b err=%b drop=%0d want 0 0 0",
                         quiesced, cnt_err, drop_cnt);
    end
    idle_in();
    Resetb = 1;
  endtask

  task automatic test_basic();
    t_if_ccip_c0_Tx req;
    do_reset();
    offset = 64'h5000;
    req = rand_c0(1);
    req.hdr.address = 42'h100;
    req.hdr.cl_len = 2'd0;
    in_c0 = req;
    tick();
    in_c0 = '0;
    n_checks++;
    if (dut.rd_out !== 4'd1 || out_c0.valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_t1: got rd_out=%0d valid=%b want 1 0", dut.rd_out, out_c0.valid);
    end
    tick();
    req.hdr.address = 42'h5100;
    n_checks++;
    if (out_c0 !== req) begin
      n_fail++; $display("FAIL basic_t2: got %h want %h", out_c0, req);
    end
    tick();
    n_checks++;
    if (out_c0.valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_t3: got valid=%b want 0", out_c0.valid);
    end
  endtask

  task automatic test_wrap();
    t_if_ccip_c0_Tx r0, e0;
    t_if_ccip_c1_Tx r1, e1;
    do_reset();
    offset = 64'h20;
    r0 = rand_c0(1); r0.hdr.address = 42'h3FF_FFFF_FFF0;
    r1 = rand_c1(1); r1.hdr.address = 42'h3FF_FFFF_FFF0;
    in_c0 = r0; in_c1 = r1;
    tick();
    idle_in();
    tick();
    e0 = r0; e0.hdr.address = 42'h10;
    e1 = r1; e1.hdr.address = 42'h10;
    n_checks++;
    if (out_c0 !== e0) begin
      n_fail++; $display("FAIL wrap_c0: got %h want %h", out_c0, e0);
    end
    n_checks++;
    if (out_c1 !== e1) begin
      n_fail++; $display("FAIL wrap_c1: got %h want %h", out_c1, e1);
    end
  endtask

  task automatic test_offset_change();
    t_if_ccip_c0_Tx r0;
    t_if_ccip_c1_Tx r1;
    do_reset();
    offset = 64'h1000;
    r0 = rand_c0(1); r0.hdr.address = 42'h40;
    in_c0 = r0;
    tick();
    in_c0 = '0;
    offset = 64'h2000;
    r1 = rand_c1(1); r1.hdr.address = 42'h80;
    in_c1 = r1;
    tick();
    in_c1 = '0;
    n_checks++;
    if (out_c0.valid !== 1'b1 || out_c0.hdr.address !== 42'h1040) begin
      n_fail++; $display("FAIL offset_hold: got v=%b addr=%h want 1 1040", out_c0.valid, out_c0.hdr.address);
    end
    tick();
    n_checks++;
    if (out_c1.valid !== 1'b1 || out_c1.hdr.address !== 42'h2080) begin
      n_fail++; $display("FAIL offset_new: got v=%b addr=%h want 1 2080", out_c1.valid, out_c1.hdr.address);
    end
  endtask

  task automatic test_drain();
    t_if_ccip_c1_Tx r1;
    do_reset();
    r1 = rand_c1(1); r1.hdr.cl_len = 2'd3; r1.hdr.address = 42'h200;
    in_c1 = r1;
    tick();
    in_c1 = rand_c1(1);
    afu_reset = 1;
    tick();
    in_c1 = '0;
    n_checks++;
    if (drop_cnt !== 4'd1 || dut.wr_out !== 4'd4) begin
      n_fail++; $display("FAIL drain_drop: got drop=%0d wr_out=%0d want 1 4", drop_cnt, dut.wr_out);
    end
    n_checks++;
    if (out_c1.valid !== 1'b1 || out_c1.hdr.address !== 42'h200) begin
      n_fail++; $display("FAIL drain_inflight: got v=%b addr=%h want 1 200", out_c1.valid, out_c1.hdr.address);
    end
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (quiesced !== 1'b0) begin
        n_fail++; $display("FAIL drain_early_q%0d: got %b want 0", k, quiesced);
      end
      rsp_c1_line = 1;
      tick();
      rsp_c1_line = 0;
    end
    n_checks++;
    if (quiesced !== 1'b0 || dut.wr_out !== 4'd0) begin
      n_fail++; $display("FAIL drain_last: got q=%b wr_out=%0d want 0 0", quiesced, dut.wr_out);
    end
    tick();
    n_checks++;
    if (quiesced !== 1'b1) begin
      n_fail++; $display("FAIL drain_quiet: got %b want 1", quiesced);
    end
    in_c0 = rand_c0(1);
    tick();
    in_c0 = '0;
    n_checks++;
    if (drop_cnt !== 4'd2 || quiesced !== 1'b1) begin
      n_fail++; $display("FAIL quiet_block: got drop=%0d q=%b want 2 1", drop_cnt, quiesced);
    end
    afu_reset = 0;
    tick();
    n_checks++;
    if (quiesced !== 1'b0) begin
      n_fail++; $display("FAIL quiet_exit: got %b want 0", quiesced);
    end
  endtask

  task automatic test_abort();
    t_if_ccip_c0_Tx r0;
    t_if_ccip_c1_Tx r1;
    do_reset();
    offset = 64'h700;
    r1 = rand_c1(1); r1.hdr.cl_len = 2'd3;
    in_c1 = r1;
    tick();
    in_c1 = '0;
    afu_reset = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      rsp_c1_line = 1; tick(); rsp_c1_line = 0;
    end
    n_checks++;
    if (dut.wr_out !== 4'd2 || quiesced !== 1'b0) begin
      n_fail++; $display("FAIL abort_mid: got wr_out=%0d q=%b want 2 0", dut.wr_out, quiesced);
    end
    afu_reset = 0;
    tick();
    r0 = rand_c0(1); r0.hdr.cl_len = 2'd1; r0.hdr.address = 42'h300;
    in_c0 = r0;
    tick();
    in_c0 = '0;
    n_checks++;
    if (dut.rd_out !== 4'd2) begin
      n_fail++; $display("FAIL abort_count: got rd_out=%0d want 2", dut.rd_out);
    end
    tick();
    n_checks++;
    if (out_c0.valid !== 1'b1 || out_c0.hdr.address !== 42'hA00 || drop_cnt !== 4'd0) begin
      n_fail++; $display("FAIL abort_pass: got v=%b addr=%h drop=%0d want 1 a00 0",
                         out_c0.valid, out_c0.hdr.address, drop_cnt);
    end
  endtask

  task automatic test_cnt_err();
    do_reset();
    rsp_c0_line = 1;
    tick();
    rsp_c0_line = 0;
    n_checks++;
    if (cnt_err !== 1'b1 || dut.rd_out !== 4'd0) begin
      n_fail++; $display("FAIL underflow: got err=%b rd_out=%0d want 1 0", cnt_err, dut.rd_out);
    end
    tick(); tick(); tick();
    n_checks++;
    if (cnt_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b want 1", cnt_err);
    end
    do_reset();
    n_checks++;
    if (cnt_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 0", cnt_err);
    end
  endtask

  task automatic test_overflow();
    t_if_ccip_c1_Tx r1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (cnt_err !== 1'b0 || dut.wr_out !== 4'(k * 4)) begin
        n_fail++; $display("FAIL ovf_pre%0d: got err=%b wr_out=%0d want 0 %0d", k, cnt_err, dut.wr_out, k * 4);
      end
      r1 = rand_c1(1); r1.hdr.cl_len = 2'd3;
      in_c1 = r1;
      tick();
    end
    in_c1 = '0;
    n_checks++;
    if (cnt_err !== 1'b1 || dut.wr_out !== 4'd15) begin
      n_fail++; $display("FAIL ovf_sat: got err=%b wr_out=%0d want 1 15", cnt_err, dut.wr_out);
    end
  endtask

  task automatic test_drop_sat();
    do_reset();
    afu_reset = 1;
    in_c0 = rand_c0(1); in_c1 = rand_c1(1);
    tick();
    n_checks++;
    if (drop_cnt !== 4'd2) begin
      n_fail++; $display("FAIL drop_pair: got %0d want 2", drop_cnt);
    end
    for (int k = 0; k < 8; k++) tick();
    idle_in();
    n_checks++;
    if (drop_cnt !== 4'd15) begin
      n_fail++; $display("FAIL drop_sat: got %0d want 15", drop_cnt);
    end
    afu_reset = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_c0 = rand_c0($urandom_range(0, 9) < 3);
      in_c1 = rand_c1($urandom_range(0, 9) < 3);
      rsp_c0_line = (m_rd > 0) && ($urandom_range(0, 9) < 8);
      rsp_c1_line = (m_wr > 0) && ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 39) == 0) afu_reset = ~afu_reset;
      if ($urandom_range(0, 7) == 0) offset = {$urandom, $urandom};
      tick();
      n_checks++;
      if (out_c0.valid !== m_p2_c0.valid || (m_p2_c0.valid && out_c0 !== m_p2_c0)) begin
        n_fail++; $display("FAIL rand_c0 cyc %0d: got %h want %h", i, out_c0, m_p2_c0);
      end
      n_checks++;
      if (out_c1.valid !== m_p2_c1.valid || (m_p2_c1.valid && out_c1 !== m_p2_c1)) begin
        n_fail++; $display("FAIL rand_c1 cyc %0d: got v=%b addr=%h want v=%b addr=%h", i,
                           out_c1.valid, out_c1.hdr.address, m_p2_c1.valid, m_p2_c1.hdr.address);
      end
      n_checks++;
      if (quiesced !== m_q || cnt_err !== m_err || drop_cnt !== 4'(m_drop)) begin
        n_fail++; $display("FAIL rand_status cyc %0d: got q=%b err=%b drop=%0d want %b %b %0d",
                           i, quiesced, cnt_err, drop_cnt, m_q, m_err, m_drop);
      end
    end
    idle_in();
    afu_reset = 0;
    tick(); tick();
  endtask

  initial begin
    Resetb = 0; afu_reset = 0; offset = '0;
    idle_in();
    test_reset();
    test_basic();
    test_wrap();
    test_offset_change();
    test_drain();
    test_abort();
    test_cnt_err();
    test_overflow();
    test_drop_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
